// File: rtl/fft_capture_sched_if.sv
// fft_capture_sched_if
//   Groups the FFT sample stream and the FIFO write/handoff signals used by
//   the capture scheduler.
//   master : environment side (drives the FFT stream and FIFO status flags)
//   slave  : scheduler side (consumes the stream, drives the FIFO write port
//            and the reader start level)
//   Signals: i_valid/i_addr/i_data  FFT output sample
//            fifo_full/fifo_empty   FIFO wr_full / rd_empty (rd_empty is async)
//            wr_en/wr_data          FIFO write port
//            rd_go                  level to reader: complete frame ready
interface fft_capture_sched_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 11
);
    logic              i_valid;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_go;

    modport master (
        output i_valid, i_addr, i_data, fifo_full, fifo_empty,
        input  wr_en, wr_data, rd_go
    );

    modport slave (
        input  i_valid, i_addr, i_data, fifo_full, fifo_empty,
        output wr_en, wr_data, rd_go
    );
endinterface

// File: rtl/fft_capture_sched.sv
// fft_capture_sched
//   Schedules snapshot capture of FFT output frames into the dual-clock UART
//   FIFO. Arms on request or in auto mode, optionally skips frames, aligns to
//   the frame start bin, writes exactly FRAME_LEN samples, then hands the FIFO
//   to the uart_clk reader and waits for it to drain before re-arming.
//   Ports:
//     data_clk, rst        write-side clock, async active-low reset
//     bus (slave)          FFT stream in, FIFO write port / rd_go out
//     capture_req          single-shot capture request pulse (IDLE only)
//     auto_mode            re-arm automatically after every drain
//     abort                cancel current activity, return to IDLE
//     decim                capture 1 of every decim+1 frames while armed
//     busy                 state != IDLE
//     overflow             sticky: a sample was dropped on fifo_full
//     frame_cnt            completed (drained) captures, wrapping
module fft_capture_sched #(
    parameter int DATA_W     = 12,
    parameter int ADDR_W     = 11,
    parameter int FRAME_LEN  = 1024,
    parameter int START_ADDR = 1,
    parameter int DECIM_W    = 4
) (
    input  logic               data_clk,
    input  logic               rst,
    fft_capture_sched_if.slave bus,
    input  logic               capture_req,
    input  logic               auto_mode,
    input  logic               abort,
    input  logic [DECIM_W-1:0] decim,
    output logic               busy,
    output logic               overflow,
    output logic [15:0]        frame_cnt
);
    // bin_cnt must be able to hold FRAME_LEN itself (up to 2**ADDR_W)
    localparam int                BIN_W    = ADDR_W + 1;
    localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(FRAME_LEN);
    localparam logic [ADDR_W-1:0] START    = ADDR_W'(START_ADDR);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [DECIM_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [BIN_W-1:0]   bin_cnt_q, bin_cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               rd_go_q, rd_go_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               seen_data_q, seen_data_d;
    logic               empty_s1_q, empty_s_q;

    logic               frame_start;
    logic               take;
    logic [BIN_W-1:0]   bin_inc;

    assign frame_start = bus.i_valid && (bus.i_addr == START);
    assign bin_inc     = bin_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        bin_cnt_d   = bin_cnt_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        rd_go_d     = rd_go_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        seen_data_d = seen_data_q;
        take        = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            rd_go_d     = 1'b0;
            bin_cnt_d   = '0;
            skip_cnt_d  = '0;
            seen_data_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture_req || auto_mode) begin
                        state_d    = ARM;
                        skip_cnt_d = '0;
                        bin_cnt_d  = '0;
                    end
                    if (capture_req) overflow_d = 1'b0;
                end
                ARM: begin
                    if (frame_start) begin
                        if (skip_cnt_q == decim) begin
                            take      = 1'b1;
                            bin_cnt_d = BIN_W'(1);
                            if (LAST_BIN == BIN_W'(1)) begin
                                state_d = DRAIN;
                                rd_go_d = 1'b1;
                            end else begin
                                state_d = CAPTURE;
                            end
                        end else begin
                            skip_cnt_d = skip_cnt_q + 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (bus.i_valid) begin
                        take      = 1'b1;
                        bin_cnt_d = bin_inc;
                        if (bin_inc == LAST_BIN) begin
                            state_d = DRAIN;
                            rd_go_d = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!empty_s_q) seen_data_d = 1'b1;
                    if (seen_data_q && empty_s_q) begin
                        rd_go_d     = 1'b0;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        seen_data_d = 1'b0;
                        bin_cnt_d   = '0;
                        skip_cnt_d  = '0;
                        state_d     = auto_mode ? ARM : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A full FIFO drops the sample but the bin still counts, keeping the
        // capture window the same length in time.
        if (take) begin
            if (bus.fifo_full) begin
                overflow_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_data_d = bus.i_data;
            end
        end
    end

    always_ff @(posedge data_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            skip_cnt_q  <= '0;
            bin_cnt_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            rd_go_q     <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
            seen_data_q <= 1'b0;
            empty_s1_q  <= 1'b1;
            empty_s_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            bin_cnt_q   <= bin_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            rd_go_q     <= rd_go_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
            seen_data_q <= seen_data_d;
            empty_s1_q  <= bus.fifo_empty;
            empty_s_q   <= empty_s1_q;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_data = wr_data_q;
    assign bus.rd_go   = rd_go_q;
    assign busy        = (state_q != IDLE);
    assign overflow    = overflow_q;
    assign frame_cnt   = frame_cnt_q;
endmodule
